// File: rtl/fcmp_pipe_if.sv
// Issue-side and writeback-side handshake bundle for the fcmp_pipe compare/select unit.
// The master modport belongs to the block that issues operations and consumes results.
interface fcmp_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [W-1:0]     x1;
    logic [W-1:0]     x2;
    logic [TAG_W-1:0] tag_in;

    logic             out_valid;
    logic             out_ready;
    logic             y;
    logic [W-1:0]     r;
    logic             nv;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, op, x1, x2, tag_in, out_ready,
        input  in_ready, out_valid, y, r, nv, tag_out
    );

    modport slave (
        input  in_valid, op, x1, x2, tag_in, out_ready,
        output in_ready, out_valid, y, r, nv, tag_out
    );
endinterface

// File: rtl/fcmp_pipe.sv
// Pipelined floating-point compare/select (FEQ/FLT/FLE/FMIN/FMAX) between FPU issue and writeback.
// The result is fully formed at the input; the STAGES registers only carry it with bubble collapsing.
module fcmp_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input logic        clk,
    input logic        rst,
    fcmp_pipe_if.slave io
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int DW = TAG_W + 1 + W + 1;

    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FLT  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FMIN = 3'd3;
    localparam logic [2:0] OP_FMAX = 3'd4;

    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("fcmp_pipe: STAGES must be in the range 1..4");
        end
    endgenerate

    // Operand classification
    logic             s1, s2;
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] m1, m2;
    logic [W-2:0]     mag1, mag2;
    logic             nan1, nan2, zero1, zero2;
    logic             mag_lt, mag_eq;

    assign s1    = io.x1[W-1];
    assign s2    = io.x2[W-1];
    assign e1    = io.x1[W-2:MAN_W];
    assign e2    = io.x2[W-2:MAN_W];
    assign m1    = io.x1[MAN_W-1:0];
    assign m2    = io.x2[MAN_W-1:0];
    assign mag1  = io.x1[W-2:0];
    assign mag2  = io.x2[W-2:0];
    assign nan1  = (&e1) && (|m1);
    assign nan2  = (&e2) && (|m2);
    assign zero1 = (mag1 == '0);
    assign zero2 = (mag2 == '0);
    assign mag_lt = (mag1 < mag2);
    assign mag_eq = (mag1 == mag2);

    // Ordered relation for non-NaN operands; infinities and denormals fall out of the raw-bit order.
    logic lt, eq;

    always_comb begin
        lt = 1'b0;
        eq = 1'b0;
        if (zero1 && zero2) begin
            eq = 1'b1;
        end else if (s1 != s2) begin
            lt = s1;
        end else if (!s1) begin
            lt = mag_lt;
            eq = mag_eq;
        end else begin
            lt = !mag_lt && !mag_eq;
            eq = mag_eq;
        end
    end

    // Select for FMIN/FMAX: differently signed zeros resolve by sign, equal operands keep x1.
    logic want_min, zero_pair, pick_x1;

    assign want_min  = (io.op == OP_FMIN);
    assign zero_pair = zero1 && zero2 && (s1 != s2);
    assign pick_x1   = zero_pair ? (s1 == want_min) : (eq || (lt == want_min));

    logic         res_y;
    logic [W-1:0] res_r;
    logic         res_nv;

    always_comb begin
        res_y  = 1'b0;
        res_r  = '0;
        res_nv = 1'b0;
        case (io.op)
            OP_FEQ, OP_FLT, OP_FLE: begin
                if (nan1 || nan2) begin
                    res_nv = 1'b1;
                end else if (io.op == OP_FEQ) begin
                    res_y = eq;
                end else if (io.op == OP_FLT) begin
                    res_y = lt;
                end else begin
                    res_y = lt || eq;
                end
            end
            OP_FMIN, OP_FMAX: begin
                if (nan1 && nan2) begin
                    res_r  = CANON_NAN;
                    res_nv = 1'b1;
                end else if (nan1) begin
                    res_r  = io.x2;
                    res_nv = 1'b1;
                end else if (nan2) begin
                    res_r  = io.x1;
                    res_nv = 1'b1;
                end else begin
                    res_r = pick_x1 ? io.x1 : io.x2;
                end
            end
            default: res_nv = 1'b1;
        endcase
    end

    logic [DW-1:0] res_d;
    assign res_d = {io.tag_in, res_nv, res_r, res_y};

    // Handshake: a transfer happens on a cycle where both valid and ready are high at the
    // rising edge. Stage k can load whenever it or any later stage is empty, or the output
    // is being accepted; this lets bubbles collapse under a stall. in_ready is that condition
    // for stage 0 and is combinational from out_ready. Results leave strictly in order.
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] can_load;
    logic [DW-1:0]     d [STAGES];

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            can_load[k] = io.out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!v[j]) can_load[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) d[k] <= '0;
        end else begin
            if (can_load[0]) begin
                v[0] <= io.in_valid;
                if (io.in_valid) d[0] <= res_d;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (can_load[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) d[k] <= d[k-1];
                end
            end
        end
    end

    logic [TAG_W-1:0] o_tag;
    logic             o_nv;
    logic [W-1:0]     o_r;
    logic             o_y;

    assign {o_tag, o_nv, o_r, o_y} = d[STAGES-1];

    // Outputs read as zero whenever no result is present.
    assign io.in_ready  = can_load[0];
    assign io.out_valid = v[STAGES-1];
    assign io.y         = o_y && v[STAGES-1];
    assign io.nv        = o_nv && v[STAGES-1];
    assign io.r         = o_r & {W{v[STAGES-1]}};
    assign io.tag_out   = o_tag & {TAG_W{v[STAGES-1]}};
endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed bench for fcmp_pipe: a STAGES=2 single-precision unit plus STAGES=1, STAGES=4
// single-precision and STAGES=2 double-precision instances fed with equivalent operands.
module tb_fcmp_pipe;
    localparam int STAGES_MAIN = 2;
    localparam int NV = 20;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fcmp_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(5)) bus ();
    fcmp_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(5)) b1 ();
    fcmp_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(5)) b4 ();
    fcmp_pipe_if #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) bd ();

    fcmp_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(STAGES_MAIN), .TAG_W(5)) dut    (.clk(clk), .rst(rst), .io(bus));
    fcmp_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(1),           .TAG_W(5)) dut_s1 (.clk(clk), .rst(rst), .io(b1));
    fcmp_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(4),           .TAG_W(5)) dut_s4 (.clk(clk), .rst(rst), .io(b4));
    fcmp_pipe #(.EXP_W(11), .MAN_W(52), .STAGES(2),           .TAG_W(5)) dut_dp (.clk(clk), .rst(rst), .io(bd));

    // Directed vectors: op, single operands/result, expected y/nv, double operands/result.
    localparam logic [2:0] T_OP [NV] = '{
        3'd2, 3'd1, 3'd2, 3'd0, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3,
        3'd4, 3'd1, 3'd3, 3'd5, 3'd1, 3'd0, 3'd0, 3'd4, 3'd2, 3'd4};
    localparam logic [31:0] T_X1S [NV] = '{
        32'h3F800000, 32'hBF800000, 32'h80000000, 32'h80000000, 32'h7FC00000,
        32'h7F800001, 32'h7FC00000, 32'h00000000, 32'h00000000, 32'h80000000,
        32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h7F800000,
        32'h3F800000, 32'h7FC00000, 32'h3F800000, 32'hFF800000, 32'hBF800000};
    localparam logic [31:0] T_X2S [NV] = '{
        32'h40000000, 32'hC0000000, 32'h00000000, 32'h00000000, 32'h3F800000,
        32'hC0400000, 32'h7F800001, 32'h80000000, 32'h80000000, 32'h00000000,
        32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000,
        32'h3F800000, 32'h7FC00000, 32'h3F800000, 32'hC0400000, 32'h3F800000};
    localparam logic [31:0] T_RS [NV] = '{
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'hC0400000, 32'h7FC00000, 32'h80000000, 32'h00000000, 32'h80000000,
        32'h40000000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000};
    localparam logic T_Y  [NV] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic T_NV [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [63:0] T_X1D [NV] = '{
        64'h3FF0000000000000, 64'hBFF0000000000000, 64'h8000000000000000, 64'h8000000000000000,
        64'h7FF8000000000000, 64'h7FF0000000000001, 64'h7FF8000000000000, 64'h0000000000000000,
        64'h0000000000000000, 64'h8000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000,
        64'h4000000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 64'h3FF0000000000000,
        64'h7FF8000000000000, 64'h3FF0000000000000, 64'hFFF0000000000000, 64'hBFF0000000000000};
    localparam logic [63:0] T_X2D [NV] = '{
        64'h4000000000000000, 64'hC000000000000000, 64'h0000000000000000, 64'h0000000000000000,
        64'h3FF0000000000000, 64'hC008000000000000, 64'h7FF0000000000001, 64'h8000000000000000,
        64'h8000000000000000, 64'h0000000000000000, 64'h4000000000000000, 64'h4000000000000000,
        64'h3FF0000000000000, 64'h4000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000,
        64'h7FF8000000000000, 64'h3FF0000000000000, 64'hC008000000000000, 64'h3FF0000000000000};
    localparam logic [63:0] T_RD [NV] = '{
        64'h0000000000000000, 64'h0000000000000000, 64'h0000000000000000, 64'h0000000000000000,
        64'h0000000000000000, 64'hC008000000000000, 64'h7FF8000000000000, 64'h8000000000000000,
        64'h0000000000000000, 64'h8000000000000000, 64'h4000000000000000, 64'h0000000000000000,
        64'h3FF0000000000000, 64'h0000000000000000, 64'h0000000000000000, 64'h0000000000000000,
        64'h0000000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 64'h3FF0000000000000};

    // Driver tasks; every test starts and ends 1 time unit after a rising edge.
    task automatic drive_main(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.x1       = a;
        bus.x2       = b;
        bus.tag_in   = tag;
    endtask

    task automatic drive_cfg(input int i);
        b1.in_valid = 1'b1; b1.op = T_OP[i]; b1.x1 = T_X1S[i]; b1.x2 = T_X2S[i]; b1.tag_in = 5'(i);
        b4.in_valid = 1'b1; b4.op = T_OP[i]; b4.x1 = T_X1S[i]; b4.x2 = T_X2S[i]; b4.tag_in = 5'(i);
        bd.in_valid = 1'b1; bd.op = T_OP[i]; bd.x1 = T_X1D[i]; bd.x2 = T_X2D[i]; bd.tag_in = 5'(i);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.y !== 1'b0 || bus.r !== 32'h0 || bus.nv !== 1'b0 || bus.tag_out !== 5'h0) begin
            $display("FAIL reset_outputs: got valid=%b y=%b r=%h nv=%b tag=%h, expected all zero",
                     bus.out_valid, bus.y, bus.r, bus.nv, bus.tag_out);
            failures++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
            failures++;
        end
        checks++;
        if ({b1.out_valid, b4.out_valid, bd.out_valid} !== 3'b000 || {b1.in_ready, b4.in_ready, bd.in_ready} !== 3'b111) begin
            $display("FAIL reset_configs: got out_valid=%b%b%b in_ready=%b%b%b expected 000/111",
                     b1.out_valid, b4.out_valid, bd.out_valid, b1.in_ready, b4.in_ready, bd.in_ready);
            failures++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        drive_main(3'd2, 32'h3F800000, 32'h40000000, 5'd9);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        for (int c = 1; c <= STAGES_MAIN; c++) begin
            if (c > 1) @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== (c == STAGES_MAIN)) begin
                $display("FAIL latency_valid: cycle %0d got out_valid=%b expected %b", c, bus.out_valid, c == STAGES_MAIN);
                failures++;
            end
        end
        checks++;
        if (bus.y !== 1'b1 || bus.nv !== 1'b0 || bus.tag_out !== 5'd9 || bus.r !== 32'h0) begin
            $display("FAIL latency_result: got y=%b nv=%b tag=%0d r=%h expected y=1 nv=0 tag=9 r=0",
                     bus.y, bus.nv, bus.tag_out, bus.r);
            failures++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL latency_single: got out_valid=%b after transfer expected 0", bus.out_valid);
            failures++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_compare;
        int n;
        for (int i = 0; i < NV; i++) begin
            if (T_OP[i] <= 3'd2) begin
                drive_main(T_OP[i], T_X1S[i], T_X2S[i], 5'(i));
                @(posedge clk); #1 bus.in_valid = 1'b0;
                n = 0;
                @(negedge clk);
                while (!bus.out_valid && n < 10) begin @(negedge clk); n++; end
                checks++;
                if (!bus.out_valid) begin
                    $display("FAIL compare_timeout: vector %0d got no out_valid expected one", i);
                    failures++;
                end else if (bus.y !== T_Y[i] || bus.nv !== T_NV[i] || bus.r !== T_RS[i] || bus.tag_out !== 5'(i)) begin
                    $display("FAIL compare_vec%0d: got y=%b nv=%b r=%h tag=%0d expected y=%b nv=%b r=%h tag=%0d",
                             i, bus.y, bus.nv, bus.r, bus.tag_out, T_Y[i], T_NV[i], T_RS[i], i);
                    failures++;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_select;
        int n;
        for (int i = 0; i < NV; i++) begin
            if (T_OP[i] >= 3'd3) begin
                drive_main(T_OP[i], T_X1S[i], T_X2S[i], 5'(i));
                @(posedge clk); #1 bus.in_valid = 1'b0;
                n = 0;
                @(negedge clk);
                while (!bus.out_valid && n < 10) begin @(negedge clk); n++; end
                checks++;
                if (!bus.out_valid) begin
                    $display("FAIL select_timeout: vector %0d got no out_valid expected one", i);
                    failures++;
                end else if (bus.y !== T_Y[i] || bus.nv !== T_NV[i] || bus.r !== T_RS[i] || bus.tag_out !== 5'(i)) begin
                    $display("FAIL select_vec%0d: got y=%b nv=%b r=%h tag=%0d expected y=%b nv=%b r=%h tag=%0d",
                             i, bus.y, bus.nv, bus.r, bus.tag_out, T_Y[i], T_NV[i], T_RS[i], i);
                    failures++;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int got = 0;
        logic held = 1'b0;
        logic saw_drop = 1'b0;
        logic [4:0] h_tag = '0;
        logic [31:0] h_r = '0;
        logic [31:0] e;
        exp_q.delete();
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            bus.in_valid  = (sent < 6);
            bus.op        = 3'd4;
            bus.x1        = 32'(sent);
            bus.x2        = 32'h0;
            bus.tag_in    = 5'(sent);
            bus.out_ready = !(cyc >= 3 && cyc < 7);
            @(negedge clk);
            checks++;
            if (bus.in_ready !== (bus.out_ready || exp_q.size() < STAGES_MAIN)) begin
                $display("FAIL b2b_in_ready: cycle %0d got %b expected %b", cyc, bus.in_ready,
                         bus.out_ready || exp_q.size() < STAGES_MAIN);
                failures++;
            end
            if (!bus.in_ready) saw_drop = 1'b1;
            if (held) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.tag_out !== h_tag || bus.r !== h_r) begin
                    $display("FAIL b2b_hold: cycle %0d got valid=%b tag=%0d r=%h expected valid=1 tag=%0d r=%h",
                             cyc, bus.out_valid, bus.tag_out, bus.r, h_tag, h_r);
                    failures++;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra: got tag=%0d expected no output", bus.tag_out);
                    failures++;
                end else begin
                    e = exp_q.pop_front();
                    if (bus.tag_out !== e[4:0] || bus.r !== e) begin
                        $display("FAIL b2b_order: got tag=%0d r=%h expected tag=%0d r=%h", bus.tag_out, bus.r, e[4:0], e);
                        failures++;
                    end
                end
                got++;
            end
            held  = bus.out_valid && !bus.out_ready;
            h_tag = bus.tag_out;
            h_r   = bus.r;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(32'(sent));
                sent++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (got != 6 || exp_q.size() != 0) begin
            $display("FAIL b2b_count: got %0d results with %0d pending expected 6 and 0", got, exp_q.size());
            failures++;
        end
        checks++;
        if (saw_drop !== 1'b1) begin
            $display("FAIL b2b_backpressure: got in_ready never low expected a drop during the stall");
            failures++;
        end
    endtask

    task automatic test_reset_flight;
        int stale = 0;
        int n = 0;
        bus.out_ready = 1'b0;
        drive_main(3'd0, 32'h3F800000, 32'h3F800000, 5'd20);
        @(posedge clk); #1;
        drive_main(3'd0, 32'h3F800000, 32'h3F800000, 5'd21);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL flight_reset: got out_valid=%b in_ready=%b expected 0 and 1", bus.out_valid, bus.in_ready);
            failures++;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
            @(posedge clk); #1;
        end
        checks++;
        if (stale != 0) begin
            $display("FAIL flight_stale: got %0d stale result cycles expected 0", stale);
            failures++;
        end
        drive_main(3'd1, 32'h3F800000, 32'h40000000, 5'd22);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        while (!bus.out_valid && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.y !== 1'b1 || bus.tag_out !== 5'd22) begin
            $display("FAIL flight_resume: got valid=%b y=%b tag=%0d expected valid=1 y=1 tag=22",
                     bus.out_valid, bus.y, bus.tag_out);
            failures++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_configs;
        for (int i = 0; i < NV; i++) begin
            drive_cfg(i);
            @(posedge clk); #1;
            b1.in_valid = 1'b0; b4.in_valid = 1'b0; bd.in_valid = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                if (c > 1) @(posedge clk);
                @(negedge clk);
                checks += 3;
                if (b1.out_valid !== (c == 1)) begin
                    $display("FAIL cfg_s1_valid: vec %0d cycle %0d got %b expected %b", i, c, b1.out_valid, c == 1);
                    failures++;
                end
                if (b4.out_valid !== (c == 4)) begin
                    $display("FAIL cfg_s4_valid: vec %0d cycle %0d got %b expected %b", i, c, b4.out_valid, c == 4);
                    failures++;
                end
                if (bd.out_valid !== (c == 2)) begin
                    $display("FAIL cfg_dp_valid: vec %0d cycle %0d got %b expected %b", i, c, bd.out_valid, c == 2);
                    failures++;
                end
                if (c == 1) begin
                    checks++;
                    if (b1.y !== T_Y[i] || b1.nv !== T_NV[i] || b1.r !== T_RS[i] || b1.tag_out !== 5'(i)) begin
                        $display("FAIL cfg_s1_vec%0d: got y=%b nv=%b r=%h tag=%0d expected y=%b nv=%b r=%h tag=%0d",
                                 i, b1.y, b1.nv, b1.r, b1.tag_out, T_Y[i], T_NV[i], T_RS[i], i);
                        failures++;
                    end
                end
                if (c == 2) begin
                    checks++;
                    if (bd.y !== T_Y[i] || bd.nv !== T_NV[i] || bd.r !== T_RD[i] || bd.tag_out !== 5'(i)) begin
                        $display("FAIL cfg_dp_vec%0d: got y=%b nv=%b r=%h tag=%0d expected y=%b nv=%b r=%h tag=%0d",
                                 i, bd.y, bd.nv, bd.r, bd.tag_out, T_Y[i], T_NV[i], T_RD[i], i);
                        failures++;
                    end
                end
                if (c == 4) begin
                    checks++;
                    if (b4.y !== T_Y[i] || b4.nv !== T_NV[i] || b4.r !== T_RS[i] || b4.tag_out !== 5'(i)) begin
                        $display("FAIL cfg_s4_vec%0d: got y=%b nv=%b r=%h tag=%0d expected y=%b nv=%b r=%h tag=%0d",
                                 i, b4.y, b4.nv, b4.r, b4.tag_out, T_Y[i], T_NV[i], T_RS[i], i);
                        failures++;
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = '0; bus.x1 = '0; bus.x2 = '0; bus.tag_in = '0; bus.out_ready = 1'b1;
        b1.in_valid  = 1'b0; b1.op  = '0; b1.x1  = '0; b1.x2  = '0; b1.tag_in  = '0; b1.out_ready  = 1'b1;
        b4.in_valid  = 1'b0; b4.op  = '0; b4.x1  = '0; b4.x2  = '0; b4.tag_in  = '0; b4.out_ready  = 1'b1;
        bd.in_valid  = 1'b0; bd.op  = '0; bd.x1  = '0; bd.x2  = '0; bd.tag_in  = '0; bd.out_ready  = 1'b1;
        test_reset;
        test_latency;
        test_compare;
        test_select;
        test_back_to_back;
        test_reset_flight;
        test_configs;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got simulation still running expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fcmp_pipe.md
Name: fcmp_pipe

Overview:
- Parametrised, pipelined floating-point compare/select unit. Supersedes the combinational single-op less-or-equal comparator.
- Operations: FEQ, FLT, FLE, FMIN, FMAX on IEEE-754-style operands of configurable format.
- Sits between the FPU issue stage and writeback.
- Uses a valid/ready handshake with per-stage bubble collapsing, so downstream stalls do not lose data.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width. Operand width W = 1+EXP_W+MAN_W.
- STAGES, 2, pipeline depth / latency in cycles. Legal range 1..4; other values are an elaboration error.
- TAG_W, 5, width of the destination tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation present on inputs.
- in_ready  out  1  unit accepts operation this cycle.
- op  in  3  0=FEQ, 1=FLT, 2=FLE, 3=FMIN, 4=FMAX, 5..7 illegal.
- x1  in  W  first operand.
- x2  in  W  second operand.
- tag_in  in  TAG_W  destination tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- y  out  1  compare result; 0 for FMIN/FMAX.
- r  out  W  FMIN/FMAX result; 0 for compare ops.
- nv  out  1  invalid flag.
- tag_out  out  TAG_W  tag of the result.

Behaviour:
- Reset: all stage-valid bits clear. out_valid=0, y=0, r=0, nv=0, tag_out=0, in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight entries. No result for them is ever emitted.
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - Stage k advances when its successor is empty or the successor itself advances. The last stage advances on out_ready.
  - in_ready = !v[0] || stage 0 advances (combinational from out_ready through the chain).
  - Throughput is 1 op/cycle while out_ready=1.
  - Latency is exactly STAGES cycles from input transfer to out_valid when unstalled.
- Held output: while out_valid && !out_ready, out_valid, y, r, nv and tag_out hold stable. Bubbles behind the stalled entry collapse. Ordering is strictly FIFO.
- Stage 0 work: classify each operand as NaN (exp all ones, mant≠0), zero (exp=0, mant=0), and sign. Compute the magnitude compare on {exp,mant}.
- Remaining stages carry registered results unchanged. The final result is computed by the end of stage 0, or combinationally in stage 0 when STAGES=1.
- Ordered compare semantics:
  - Both operands zero compare equal regardless of sign.
  - Otherwise signs differ: the negative operand is smaller.
  - Both positive: use the magnitude order.
  - Both negative: use the reversed magnitude order.
  - Infinities are ordinary extreme values. Denormals use the raw-bit order.
- FEQ/FLT/FLE, any NaN operand: y=0 and nv=1. This quiet/signalling distinction is not made; any NaN sets nv, consistent with the existing comparator.
- FMIN/FMAX NaN handling:
  - Exactly one NaN operand: r = the other operand, nv=1.
  - Both NaN: r = canonical NaN (sign 0, exp all ones, mant MSB 1, rest 0), nv=1.
- FMIN/FMAX signed zeros: min(+0,-0) = -0, max(+0,-0) = +0, in either operand order.
- FMIN/FMAX equal operands: r=x1.
- Illegal op 5..7: accepted and pipelined; y=0, r=0, nv=1.
- tag_in is carried unchanged to tag_out with its operation.

Test Plan:
- Reset then single FLE, x1=0x3F800000 (1.0), x2=0x40000000 (2.0), out_ready=1 -> out_valid exactly 2 cycles later with y=1, nv=0, tag_out=tag_in.
- Signed/zero ordering:
  - FLT x1=0xBF800000, x2=0xC0000000 -> y=0.
  - FLE x1=0x80000000, x2=0x00000000 -> y=1.
  - FEQ x1=0x80000000, x2=0x00000000 -> y=1.
- NaN cases:
  - FLE x1=0x7FC00000, x2=0x3F800000 -> y=0, nv=1.
  - FMIN x1=0x7F800001, x2=0xC0400000 -> r=0xC0400000, nv=1.
  - FMAX with both NaN -> r=0x7FC00000.
- Zero select: FMIN x1=0x00000000, x2=0x80000000 -> r=0x80000000. FMAX on the same operands -> r=0x00000000.
- Backpressure: stream 6 ops with tags 0..5 back-to-back while holding out_ready=0 for 4 cycles mid-stream.
  - in_ready drops once STAGES entries are held.
  - Outputs stay stable during the stall.
  - Tags 0..5 emerge in order, none dropped or duplicated.
- Assert rst for 1 cycle with 2 ops in flight -> out_valid=0 next cycle, no stale results afterwards. Repeat the full directed set at STAGES=1 and STAGES=4, and at EXP_W=11/MAN_W=52 with double-precision equivalents.
